// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Oversampling UART receiver with configurable data bits, parity and stop
// bits. Each bit is decided by a 2-of-3 majority vote around mid-bit. Every
// received character is tagged with framing and parity error bits and is
// queued in a FIFO read through a valid/read handshake. When a character
// arrives while the FIFO is full and is not being read, it is dropped and
// overrun pulses.
//
// Optional feature, enabled by defining the macro UART_RX_BREAK_EN:
//   A frame with all data bits 0, parity bit 0 and first stop bit 0 is a
//   line break. It is not queued; break_out pulses for one cycle instead.
//   Without the macro, break_out is tied to 0 and such a frame is queued as
//   data 0 with frame_err set.
//
// Ports:
//   clock           system clock, all logic on the rising edge
//   reset           synchronous, active-high reset
//   prescaler_max   one sample tick every prescaler_max+1 clocks
//   signal_in       asynchronous serial line, idle high
//   data_out        FIFO head character
//   frame_err_out   FIFO head: a stop bit was sampled 0
//   parity_err_out  FIFO head: parity mismatch (always 0 when PARITY=0)
//   data_valid      FIFO non-empty
//   data_read       pop the head; ignored when data_valid=0
//   fifo_count      FIFO occupancy
//   overrun         one-cycle pulse when a character is dropped
//   break_out       one-cycle pulse on a detected line break
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,   // 5..9, LSB first
   parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
   parameter int STOP_BITS  = 1,   // 1 or 2
   parameter int OVERSAMPLE = 8,   // even, >= 4
   parameter int FIFO_DEPTH = 16   // power of two, >= 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [15:0]                   prescaler_max,
   input  logic                          signal_in,
   output logic [DATA_BITS-1:0]          data_out,
   output logic                          frame_err_out,
   output logic                          parity_err_out,
   output logic                          data_valid,
   input  logic                          data_read,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overrun,
   output logic                          break_out
);

   localparam int M  = OVERSAMPLE / 2;
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = DATA_BITS + 2;

   localparam logic [SW-1:0] S_SAMP0     = SW'(M - 1);
   localparam logic [SW-1:0] S_SAMP1     = SW'(M);
   localparam logic [SW-1:0] S_DECIDE    = SW'(M + 1);
   localparam logic [SW-1:0] S_LAST      = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          ODD_PARITY  = (PARITY == 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   // Receiver state
   logic [1:0]           sync_q, sync_d;          // [0] first stage, [1] synchronised line
   logic [1:0]           sync_vld_q, sync_vld_d;  // marks when sync_q[1] holds a real sample
   logic                 line_prev_q, line_prev_d;
   logic                 armed_q, armed_d;
   state_t               state_q, state_d;
   logic [15:0]          pre_q, pre_d;
   logic [SW-1:0]        s_q, s_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [1:0]           samp_q, samp_d;
   logic                 fe_q, fe_d;
   logic                 pe_q, pe_d;
`ifdef UART_RX_BREAK_EN
   logic                 pbit_q, pbit_d;
   logic                 break_q, break_d;
`endif

   // FIFO state
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 overrun_q, overrun_d;
   logic [EW-1:0]        head_q, head_d;

   // Combinational helpers
   logic                 line;
   logic                 fall;
   logic                 tick;
   logic                 decide;
   logic                 bit_end;
   logic                 maj;
   logic                 is_break;
   logic                 push;
   logic [EW-1:0]        push_entry;
   logic                 full;
   logic                 pop;
   logic                 do_push;
   logic [EW-1:0]        head;

   assign line = sync_q[1];
   // Only a genuine 1 -> 0 transition starts a frame; armed_q blocks the
   // fake edge created when the line is already low as reset is released.
   assign fall    = armed_q & line_prev_q & ~line;
   // >= rather than == so a mid-frame drop of prescaler_max cannot stall.
   assign tick    = (pre_q >= prescaler_max);
   assign decide  = tick && (s_q == S_DECIDE);
   assign bit_end = tick && (s_q == S_LAST);
   assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);

   // -------------------------------------------------------------------------
   // Receiver next-state logic
   // -------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      sync_d      = {sync_q[0], signal_in};
      sync_vld_d  = {sync_vld_q[0], 1'b1};
      line_prev_d = line;
      armed_d     = armed_q | (sync_vld_q[1] & line);
      state_d     = state_q;
      pre_d       = pre_q;
      s_d         = s_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      samp_d      = samp_q;
      fe_d        = fe_q;
      pe_d        = pe_q;
      push        = 1'b0;
      push_entry  = {fe_q, pe_q, shift_q};
`ifdef UART_RX_BREAK_EN
      pbit_d      = pbit_q;
      break_d     = 1'b0;
      is_break    = (bit_q == '0) && (shift_q == '0) && !pbit_q && !maj;
`else
      is_break    = 1'b0;
`endif

      if (state_q == ST_IDLE) begin
         pre_d = '0;
         s_d   = '0;
         bit_d = '0;
         if (fall) begin
            state_d = ST_START;
            fe_d    = 1'b0;
            pe_d    = 1'b0;
`ifdef UART_RX_BREAK_EN
            pbit_d  = 1'b0;
`endif
         end
      end else begin
         if (tick) begin
            pre_d = '0;
            s_d   = bit_end ? '0 : s_q + SW'(1);
         end else begin
            pre_d = pre_q + 16'd1;
         end
         if (tick && (s_q == S_SAMP0)) samp_d[0] = line;
         if (tick && (s_q == S_SAMP1)) samp_d[1] = line;

         case (state_q)
            ST_START: begin
               if (decide && maj) begin
                  state_d = ST_IDLE;        // false start
               end else if (bit_end) begin
                  state_d = ST_DATA;
                  bit_d   = '0;
               end
            end
            ST_DATA: begin
               if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
               if (bit_end) begin
                  if (bit_q == B_DATA_LAST) begin
                     bit_d   = '0;
                     state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_d = bit_q + BW'(1);
                  end
               end
            end
            ST_PARITY: begin
               if (decide) begin
                  pe_d = (((^shift_q) ^ maj) != ODD_PARITY);
`ifdef UART_RX_BREAK_EN
                  pbit_d = maj;
`endif
               end
               if (bit_end) state_d = ST_STOP;
            end
            ST_STOP: begin
               if (decide && is_break) begin
`ifdef UART_RX_BREAK_EN
                  break_d = 1'b1;
`endif
                  state_d = ST_IDLE;
               end else if (decide && (bit_q == B_STOP_LAST)) begin
                  // Queue at the final stop decision and re-arm half a bit
                  // early so a back-to-back start edge is not missed.
                  push       = 1'b1;
                  push_entry = {fe_q | ~maj, pe_q, shift_q};
                  state_d    = ST_IDLE;
               end else begin
                  if (decide)  fe_d  = fe_q | ~maj;
                  if (bit_end) bit_d = bit_q + BW'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // FIFO next-state logic
   // -------------------------------------------------------------------------
   assign full = (count_q == CW'(FIFO_DEPTH));
   assign pop  = data_read && (count_q != '0);
   assign head = (count_q != '0) ? mem_q[rd_ptr_q] : head_q;

   always_comb begin
      // A full FIFO still accepts a push when the head is popped that cycle.
      do_push   = push && (!full || pop);
      overrun_d = push && full && !pop;
      wr_ptr_d  = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d   = count_q + CW'(do_push) - CW'(pop);
      head_d    = head;
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q      <= 2'b11;
         sync_vld_q  <= 2'b00;
         line_prev_q <= 1'b1;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         pre_q       <= '0;
         s_q         <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         samp_q      <= '0;
         fe_q        <= 1'b0;
         pe_q        <= 1'b0;
`ifdef UART_RX_BREAK_EN
         pbit_q      <= 1'b0;
         break_q     <= 1'b0;
`endif
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overrun_q   <= 1'b0;
         head_q      <= '0;
      end else begin
         sync_q      <= sync_d;
         sync_vld_q  <= sync_vld_d;
         line_prev_q <= line_prev_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         pre_q       <= pre_d;
         s_q         <= s_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         samp_q      <= samp_d;
         fe_q        <= fe_d;
         pe_q        <= pe_d;
`ifdef UART_RX_BREAK_EN
         pbit_q      <= pbit_d;
         break_q     <= break_d;
`endif
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overrun_q   <= overrun_d;
         head_q      <= head_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers and
   // count define what is valid, and head_q supplies the reset value of the
   // outputs while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (do_push && !reset) mem_q[wr_ptr_q] <= push_entry;
   end

   assign data_out       = head[DATA_BITS-1:0];
   assign parity_err_out = head[EW-2];
   assign frame_err_out  = head[EW-1];
   assign data_valid     = (count_q != '0);
   assign fifo_count     = count_q;
   assign overrun        = overrun_q;
`ifdef UART_RX_BREAK_EN
   assign break_out      = break_q;
`else
   assign break_out      = 1'b0;
`endif

endmodule
